// File: rtl/mem_arb_pkg.sv
// Shared types for the main-memory arbiter: FSM states, grant ids and default widths.
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 28;
    localparam int DEF_DATA_W = 128;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2,
        DONE   = 2'd3
    } arb_state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } gnt_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side and memory-side signals of the arbiter. master = the arbiter,
// slave = the environment around it (I-cache, D-cache and main memory).
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              ic_req;
    logic [ADDR_W-1:0] ic_addr;
    logic [DATA_W-1:0] ic_rdata;
    logic              ic_ready;

    logic              dc_req;
    logic              dc_wen;
    logic [ADDR_W-1:0] dc_addr;
    logic [DATA_W-1:0] dc_wdata;
    logic [DATA_W-1:0] dc_rdata;
    logic              dc_ready;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (
        input  ic_req, ic_addr, dc_req, dc_wen, dc_addr, dc_wdata, mem_rdata, mem_ready,
        output ic_rdata, ic_ready, dc_rdata, dc_ready, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport slave (
        output ic_req, ic_addr, dc_req, dc_wen, dc_addr, dc_wdata, mem_rdata, mem_ready,
        input  ic_rdata, ic_ready, dc_rdata, dc_ready, mem_read, mem_write, mem_addr, mem_wdata
    );

endinterface

// File: rtl/arb_rr2.sv
// Combinational two-requester round-robin picker: on a tie the side not granted last wins.
module arb_rr2
    import mem_arb_pkg::*;
(
    input  logic req_i,
    input  logic req_d,
    input  gnt_t last_grant,
    output logic gnt_vld,
    output gnt_t gnt_id
);

    always_comb begin
        gnt_vld = req_i | req_d;
        gnt_id  = GNT_I;
        if (req_i && req_d)
            gnt_id = (last_grant == GNT_I) ? GNT_D : GNT_I;
        else if (req_d)
            gnt_id = GNT_D;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one main-memory port between I-cache refills and D-cache refills/write-backs,
// one block transaction at a time, round-robin on simultaneous requests.
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.master bus
);

    arb_state_t state;
    gnt_t       last_grant;
    logic       gnt_vld;
    gnt_t       gnt_id;

    arb_rr2 u_rr (
        .req_i      (bus.ic_req),
        .req_d      (bus.dc_req),
        .last_grant (last_grant),
        .gnt_vld    (gnt_vld),
        .gnt_id     (gnt_id)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            last_grant    <= GNT_D;
            bus.ic_rdata  <= '0;
            bus.ic_ready  <= 1'b0;
            bus.dc_rdata  <= '0;
            bus.dc_ready  <= 1'b0;
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            // Ready is a single-cycle pulse; only the BUSY->DONE step raises it.
            bus.ic_ready <= 1'b0;
            bus.dc_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt_vld) begin
                        last_grant <= gnt_id;
                        if (gnt_id == GNT_I) begin
                            bus.mem_addr <= bus.ic_addr;
                            bus.mem_read <= 1'b1;
                            state        <= I_BUSY;
                        end else begin
                            bus.mem_addr <= bus.dc_addr;
                            if (bus.dc_wen) begin
                                bus.mem_write <= 1'b1;
                                bus.mem_wdata <= bus.dc_wdata;
                            end else begin
                                bus.mem_read  <= 1'b1;
                            end
                            state <= D_BUSY;
                        end
                    end
                end
                I_BUSY: begin
                    if (bus.mem_ready) begin
                        bus.ic_rdata <= bus.mem_rdata;
                        bus.ic_ready <= 1'b1;
                        bus.mem_read <= 1'b0;
                        state        <= DONE;
                    end
                end
                D_BUSY: begin
                    if (bus.mem_ready) begin
                        // The registered strobe tells refill from write-back; writes leave dc_rdata alone.
                        if (bus.mem_read)
                            bus.dc_rdata <= bus.mem_rdata;
                        bus.dc_ready  <= 1'b1;
                        bus.mem_read  <= 1'b0;
                        bus.mem_write <= 1'b0;
                        state         <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: stimulus pushes expected memory requests and
// completions into queues, a monitor pops and compares them as the DUT presents them.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    typedef struct packed {
        logic         wr;
        logic [27:0]  addr;
        logic [127:0] wdata;
    } exp_req_t;

    typedef struct packed {
        logic         port;   // 0 = I, 1 = D
        logic [127:0] data;
    } exp_cpl_t;

    typedef struct {
        int           lat;
        logic [127:0] data;
    } plan_t;

    logic clk;
    logic rst_n;
    logic stray_rdy;
    int   compared;
    int   mismatched;
    logic [127:0] last_dc;

    exp_req_t req_q[$];
    exp_cpl_t cpl_q[$];
    plan_t    plan_q[$];

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Memory model: each new strobe takes the next plan entry and answers on its lat-th cycle.
    initial begin : responder
        bit    in_txn;
        int    left;
        plan_t p;
        in_txn = 0;
        left = 0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            bus.mem_ready = stray_rdy;
            if (!bus.mem_read && !bus.mem_write) in_txn = 0;
            if ((bus.mem_read || bus.mem_write) && !in_txn) begin
                in_txn = 1;
                if (plan_q.size() > 0) p = plan_q.pop_front();
                else begin p.lat = 1; p.data = '0; end
                left = p.lat;
            end
            if (in_txn) begin
                if (left <= 1) begin
                    bus.mem_ready = 1'b1;
                    bus.mem_rdata = p.data;
                    in_txn = 0;
                end else begin
                    left--;
                end
            end
        end
    end

    initial begin : monitor
        logic     prev_stb;
        logic     stb;
        exp_req_t cur;
        exp_cpl_t c;
        prev_stb = 1'b0;
        cur = '0;
        forever begin
            cyc();
            if (rst_n !== 1'b1) begin
                prev_stb = 1'b0;
                continue;
            end
            stb = bus.mem_read | bus.mem_write;
            if (stb || bus.ic_ready || bus.dc_ready)
                chk("exclusive", {bus.mem_read & bus.mem_write, bus.ic_ready & bus.dc_ready}, 2'b00);
            if (stb && !prev_stb) begin
                if (req_q.size() == 0) chk("unexpected_strobe", stb, 1'b0);
                else begin
                    cur = req_q.pop_front();
                    chk("req_kind", {bus.mem_read, bus.mem_write}, {~cur.wr, cur.wr});
                    chk("req_addr", bus.mem_addr, cur.addr);
                    if (cur.wr) chk("req_wdata", bus.mem_wdata, cur.wdata);
                end
            end else if (stb) begin
                chk("addr_hold", bus.mem_addr, cur.addr);
                if (cur.wr) chk("wdata_hold", bus.mem_wdata, cur.wdata);
            end
            prev_stb = stb;
            if (bus.ic_ready || bus.dc_ready) begin
                if (cpl_q.size() == 0) chk("unexpected_ready", {bus.ic_ready, bus.dc_ready}, 2'b00);
                else begin
                    c = cpl_q.pop_front();
                    chk("cpl_port", {bus.ic_ready, bus.dc_ready}, c.port ? 2'b01 : 2'b10);
                    chk("cpl_data", c.port ? bus.dc_rdata : bus.ic_rdata, c.data);
                end
            end
        end
    end

    task automatic expect_txn(input bit is_d, input bit wen, input logic [27:0] addr,
                              input logic [127:0] wdata, input int lat, input logic [127:0] rdata);
        exp_req_t r;
        exp_cpl_t c;
        plan_t    p;
        r.wr = is_d && wen;
        r.addr = addr;
        r.wdata = wdata;
        req_q.push_back(r);
        p.lat = lat;
        p.data = rdata;
        plan_q.push_back(p);
        c.port = is_d;
        c.data = (is_d && wen) ? last_dc : rdata;
        if (is_d && !wen) last_dc = rdata;
        cpl_q.push_back(c);
    endtask

    // Single request with cycle-exact strobe/ready checks; chg>0 scrambles inputs in that busy cycle.
    task automatic run_txn(input bit is_d, input bit wen, input logic [27:0] addr,
                           input logic [127:0] wdata, input int lat, input logic [127:0] rdata,
                           input int chg);
        logic wr;
        wr = is_d && wen;
        expect_txn(is_d, wen, addr, wdata, lat, rdata);
        if (is_d) begin
            bus.dc_req = 1'b1; bus.dc_wen = wen; bus.dc_addr = addr; bus.dc_wdata = wdata;
        end else begin
            bus.ic_req = 1'b1; bus.ic_addr = addr;
        end
        for (int cy = 1; cy <= lat; cy++) begin
            cyc();
            chk("strobe", {bus.mem_read, bus.mem_write}, {~wr, wr});
            chk("ready_early", {bus.ic_ready, bus.dc_ready}, 2'b00);
            if (cy == chg) begin
                bus.ic_addr = ~addr;
                bus.dc_addr = ~addr;
                bus.dc_wdata = ~wdata;
                bus.dc_wen = ~wen;
            end
        end
        cyc();
        chk("ready", {bus.ic_ready, bus.dc_ready}, is_d ? 2'b01 : 2'b10);
        chk("strobe_off", {bus.mem_read, bus.mem_write}, 2'b00);
        bus.ic_req = 1'b0;
        bus.dc_req = 1'b0;
        cyc();
        chk("ready_pulse", {bus.ic_ready, bus.dc_ready}, 2'b00);
    endtask

    function automatic logic [27:0] ai(input int g); return 28'(32'h1000 + g); endfunction
    function automatic logic [27:0] ad(input int g); return 28'(32'h2000 + g); endfunction
    function automatic logic [127:0] di(input int g); return {4{32'h1100_0000 + 32'(g)}}; endfunction
    function automatic logic [127:0] dd(input int g); return {4{32'h2200_0000 + 32'(g)}}; endfunction

    // Both caches keep requesting; every IDLE sample is a tie, so grants must go I,D,I,D,...
    task automatic stream(input int n);
        int ni;
        int nd;
        for (int g = 0; g < n; g++) begin
            expect_txn(1'b0, 1'b0, ai(g), '0, 2 + g, di(g));
            expect_txn(1'b1, 1'b0, ad(g), '0, 1 + g, dd(g));
        end
        ni = 0;
        nd = 0;
        bus.ic_req = 1'b1; bus.ic_addr = ai(0);
        bus.dc_req = 1'b1; bus.dc_wen = 1'b0; bus.dc_addr = ad(0);
        for (int t = 0; t < 400 && (bus.ic_req || bus.dc_req); t++) begin
            cyc();
            if (bus.ic_ready) begin
                ni++;
                if (ni < n) bus.ic_addr = ai(ni); else bus.ic_req = 1'b0;
            end
            if (bus.dc_ready) begin
                nd++;
                if (nd < n) bus.dc_addr = ad(nd); else bus.dc_req = 1'b0;
            end
        end
        chk("stream_timeout", {bus.ic_req, bus.dc_req}, 2'b00);
        cyc();
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, "_strobes"}, {bus.mem_read, bus.mem_write, bus.ic_ready, bus.dc_ready}, 4'b0);
        chk({nm, "_mem_addr"}, bus.mem_addr, '0);
        chk({nm, "_mem_wdata"}, bus.mem_wdata, '0);
        chk({nm, "_ic_rdata"}, bus.ic_rdata, '0);
        chk({nm, "_dc_rdata"}, bus.dc_rdata, '0);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        compared = 0;
        mismatched = 0;
        last_dc = '0;
        stray_rdy = 1'b0;
        rst_n = 1'b0;
        bus.ic_req = 1'b0; bus.ic_addr = '0;
        bus.dc_req = 1'b0; bus.dc_wen = 1'b0; bus.dc_addr = '0; bus.dc_wdata = '0;
        cyc();
        cyc();
        check_all_zero("reset");
        rst_n = 1'b1;

        // First tie after reset goes to I, then D.
        stream(1);

        run_txn(1'b0, 1'b0, 28'h0000010, '0, 4, {16{8'hA5}}, 0);
        run_txn(1'b1, 1'b1, 28'h0000200, 128'h12345678_9ABCDEF0_0FEDCBA9_87654321, 3, '1, 0);
        // Zero-wait refill at the top of the address space.
        run_txn(1'b1, 1'b0, 28'hFFFFFFF, '0, 1, 128'hDEADBEEF_00000001_CAFEF00D_5A5A5A5A, 0);
        run_txn(1'b0, 1'b0, 28'h0000020, '0, 1, 128'h0F0F_0F0F_0F0F_0F0F_F0F0_F0F0_F0F0_F0F0, 0);
        // Inputs changed mid-transaction must not reach the memory port.
        run_txn(1'b0, 1'b0, 28'h0000030, '0, 5, 128'h3333_0000_3333_0000_3333_0000_3333_0000, 2);
        run_txn(1'b1, 1'b1, 28'h0000400, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 4, '0, 2);

        // Stray mem_ready in IDLE.
        stray_rdy = 1'b1;
        cyc();
        stray_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stray", {bus.mem_read, bus.mem_write, bus.ic_ready, bus.dc_ready}, 4'b0);
        end

        stream(3);

        // Reset in D_BUSY: strobe seen, no completion expected.
        begin
            exp_req_t r;
            plan_t    p;
            r.wr = 1'b0; r.addr = 28'h00000AB; r.wdata = '0;
            req_q.push_back(r);
            p.lat = 10; p.data = '1;
            plan_q.push_back(p);
        end
        bus.dc_req = 1'b1; bus.dc_wen = 1'b0; bus.dc_addr = 28'h00000AB;
        cyc();
        cyc();
        chk("abort_busy", bus.mem_read, 1'b1);
        rst_n = 1'b0;
        cyc();
        check_all_zero("abort");
        bus.dc_req = 1'b0;
        cyc();
        rst_n = 1'b1;
        last_dc = '0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("abort_quiet", {bus.mem_read, bus.mem_write, bus.ic_ready, bus.dc_ready}, 4'b0);
        end

        stream(1);

        cyc();
        chk("queues_drained", 32'(req_q.size() + cpl_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer sharing the single main-memory port between the I-cache (refill reads feeding instruction fetch) and the D-cache (refill reads and write-backs). It accepts one block request at a time, drives the memory handshake, and returns data plus a one-cycle ready pulse to the requester. When both caches are waiting it round-robins between them, so a fetch stream stalled on a compressed/misaligned refill cannot starve a load-use stall, and the reverse also holds.

## Interface
- ADDR_W, 28, block address width (word address [29:2] with 4-word blocks)
- DATA_W, 128, block data width
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- ic_req  in  1  I-cache read request, held until ic_ready
- ic_addr  in  ADDR_W  I-cache block address
- ic_rdata  out  DATA_W  refill data, valid only in the ic_ready cycle
- ic_ready  out  1  one-cycle completion pulse to I-cache
- dc_req  in  1  D-cache request, held until dc_ready
- dc_wen  in  1  1 = write-back, 0 = refill read
- dc_addr  in  ADDR_W  D-cache block address
- dc_wdata  in  DATA_W  write-back data
- dc_rdata  out  DATA_W  refill data, valid only in the dc_ready cycle
- dc_ready  out  1  one-cycle completion pulse to D-cache
- mem_read  out  1  memory read strobe, held until mem_ready
- mem_write  out  1  memory write strobe, held until mem_ready
- mem_addr  out  ADDR_W  memory block address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid when mem_ready
- mem_ready  in  1  memory completion, one-cycle pulse

## Operation
- States: IDLE, I_BUSY, D_BUSY, DONE.
- IDLE: sample ic_req/dc_req. Only one high: grant it. Both high: grant the port not granted last (last_grant register; reset value = D, so the first tie goes to I). Neither: stay.
- Grant: register mem_addr (and mem_wdata when granted to D with dc_wen=1), assert mem_read (I, or D with dc_wen=0) or mem_write (D with dc_wen=1), update last_grant, go to I_BUSY/D_BUSY.
- *_BUSY: hold all mem_* outputs stable. On mem_ready, capture mem_rdata into the granted port's rdata register, drop mem_read/mem_write, pulse that port's ready for exactly one cycle, and go to DONE.
- DONE: ready is high this cycle. Ignore requests. Return to IDLE next cycle. This lets the requester drop or change req before the next sample.
- Write-back completion still pulses dc_ready. dc_rdata is don't-care for writes but keeps its previous value.
- Address, data and dc_wen are latched at grant. Input changes during BUSY are ignored.
- mem_ready outside a BUSY state: ignored, no output change.
- mem_read and mem_write are never high together. ic_ready and dc_ready are never high together.
- A D-cache dirty miss arrives as two separate requests (write, then read). An I request may be granted between them by round-robin.

## Timing
- All outputs are registered.
- Reset values: every output 0, state IDLE, last_grant = D.
- Reset mid-transaction aborts the transaction: strobes drop the cycle after rst_n is sampled low, and no ready pulse is issued.
- Latency, with req sampled high in IDLE at cycle 0 and mem_ready at cycle k ≥ 1:
  - mem strobe high from cycle 1 to k
  - ready and rdata at cycle k+1
  - IDLE at cycle k+2
  - earliest next grant sampled at k+2, strobe at k+3
- Minimum turnaround between back-to-back transactions: 2 idle-side cycles (DONE, IDLE).
- Zero-wait memory (mem_ready in the same cycle as the first strobe cycle) is supported.

## Structure
- Shared package mem_arb_pkg holds:
  - state enum (IDLE, I_BUSY, D_BUSY, DONE)
  - grant encoding (GNT_I, GNT_D)
  - default ADDR_W and DATA_W
- One sub-module, arb_rr2: a combinational 2-request round-robin picker. Inputs: two requests and last_grant. Outputs: grant valid and grant id. Reused later for a second memory port if one is added.

## Test plan
- I-only read: ic_req=1, ic_addr=28'h0000010, mem_ready at cycle 4 with mem_rdata=128'hA5…A5 → mem_read=1 with mem_addr=28'h0000010 for cycles 1–4; ic_ready=1 and ic_rdata=A5…A5 at cycle 5; dc_ready stays 0.
- D write-back: dc_req=1, dc_wen=1, dc_addr=28'h0000200, dc_wdata=128'h1234…; mem_ready at cycle 3 → mem_write=1 and mem_read=0 for cycles 1–3, with mem_wdata matching; dc_ready pulse at cycle 4.
- Tie after reset: ic_req and dc_req both rise at cycle 0 → I granted first; after I's DONE, D granted; the next tie goes to I again (alternation verified over 4 ties).
- Input change while busy: change ic_addr in cycle 2 of a transaction → mem_addr unchanged until completion.
- Stray mem_ready in IDLE → no ready pulse, no strobe.
- Reset mid-transaction: rst_n=0 during D_BUSY → all outputs 0 the next cycle; no dc_ready; the first post-reset tie is granted to I.
